trunc_mult_seq: RTL and testbench
=================================

Name: trunc_mult_seq

Overview:
- Parametrised, iterative successor to the fixed 4x4 truncated-array high-half multiplier.
- Takes unsigned N-bit X and Y and returns the upper N bits of X*Y.
- The result is either exact (full product, upper half) or truncated (low columns dropped, correction constant added), selected per operation.
- Processes one Y bit per cycle behind valid/ready handshakes, for area-constrained datapaths that previously instantiated fixed-size arrays.

Parameters:
- N, 4, operand and result width (N >= 2).
- K, 1, guard columns kept below column N in truncated mode (0 <= K <= N-1).
- CW, 5, width of correction constant.
- CORR, 1, correction constant (0..2^CW-1), injected at weight 2^(N-K) in truncated mode.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- x  in  N  multiplicand.
- y  in  N  multiplier.
- trunc  in  1  1 = truncated+corrected mode, 0 = exact high half.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- z  out  N  result.
- sat  out  1  result saturated (truncated mode only).

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (reset_n=0, any time, including mid-operation):
  - state=IDLE; in_ready=1; out_valid=0; z=0; sat=0.
  - Accumulator and counter cleared; any in-flight operation is discarded with no output.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch x, y and trunc, clear the accumulator, set count=0, go to BUSY.
  - BUSY: in_ready=0. Each cycle adds partial product j=count, then count++. After the cycle with count=N-1, go to FIN.
  - FIN: one cycle. In truncated mode add CORR<<(N-K). Form z and sat, set out_valid=1, go to DONE.
  - DONE: z, sat and out_valid held stable until out_valid&out_ready. On that cycle, go to IDLE with out_valid=0 next cycle.
- Latency: result visible N+2 cycles after the accept edge. The operand-to-operand interval is at least N+3 cycles; no overlap.
- in_ready is low in BUSY, FIN and DONE. in_valid is ignored there and x/y/trunc changes have no effect.
- Partial product j:
  - Exact mode: x*y[j] << j.
  - Truncated mode: only bits x[i] with i+j >= N-K contribute; all other columns are dropped.
- Accumulator is at least 2N+CW+1 bits wide; no internal overflow.
- Exact mode: z = floor(X*Y / 2^N). sat=0 always. This can never exceed 2^N-1.
- Truncated mode: S = T + CORR*2^(N-K), where T is the kept-column sum.
  - If floor(S/2^N) > 2^N-1, then z = all ones and sat=1.
  - Otherwise z = floor(S/2^N) and sat=0.
- Operand zero: X=0 or Y=0 still takes the full N+2 cycles.
  - Exact mode: z=0.
  - Truncated mode: z = floor(CORR*2^(N-K)/2^N).
- A new operand may be accepted the cycle after the DONE handshake. There is no same-cycle pass-through.

Test Plan:
- N=4,K=1,CORR=1, trunc=0, X=15, Y=15 -> out_valid rises 6 cycles after accept; z=14, sat=0.
- Same config, trunc=1, X=15, Y=15 -> T=208, S=216; z=13, sat=0. Then X=11, Y=6, trunc=1 -> T=56, S=64, z=4. The same operands with trunc=0 -> z=4.
- N=4,K=1,CORR=31, trunc=1, X=15, Y=15 -> S=456 exceeds range; z=15, sat=1. Same config, trunc=0 -> z=14, sat=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, toggling in_valid, x and y -> z/sat/out_valid stable and in_ready=0 throughout. Release -> one transfer, in_ready=1 next cycle.
- Reset mid-operation: assert reset_n=0 asynchronously at BUSY count=2 -> outputs return to reset values immediately with no result emitted. After release, X=3, Y=5, trunc=0 completes correctly with z=0.
- Randomised back-to-back run, N=8,K=2,CORR=3, 1000 operations with random in_valid/out_ready -> every z/sat matches the formulas above and every operation yields exactly one result, in order.

Source files
------------

// File: rtl/trunc_mult_seq.sv
// trunc_mult_seq: iterative N x N unsigned multiplier returning the upper N
// bits of the product. One multiplier bit is consumed per cycle. Each operation
// selects either the exact high half or a truncated result: partial-product
// columns below N-K are dropped and CORR is added at weight 2^(N-K), with
// saturation if the corrected sum overflows N result bits.
// Operands enter through a valid/ready handshake, and results leave through one.
// Only one operation is in flight at a time.

module trunc_mult_seq #(
    parameter int N    = 4,
    parameter int K    = 1,
    parameter int CW   = 5,
    parameter int CORR = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         trunc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] z,
    output logic         sat
);

    // Accumulator is wide enough for the full product plus the correction
    // term, so no intermediate sum can overflow.
    localparam int AW   = 2 * N + CW + 1;
    localparam int HW   = AW - N;
    localparam int CNTW = (N > 2) ? $clog2(N) : 1;

    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(N - 1);
    localparam logic [AW-1:0]   CORR_EXT = AW'(CORR) << (N - K);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;

    logic [N-1:0]      x_r;
    logic [N-1:0]      y_r;
    logic              trunc_r;
    logic [AW-1:0]     acc_r;
    logic [CNTW-1:0]   count_r;

    logic              in_ready_r;
    logic              out_valid_r;
    logic [N-1:0]      z_r;
    logic              sat_r;

    logic              accept_s;
    logic [AW-1:0]     pp_s;
    logic [AW-1:0]     fin_sum_s;
    logic [HW-1:0]     hi_s;
    logic [N-1:0]      z_s;
    logic              sat_s;

    // Partial product for multiplier bit j. In truncated mode, a multiplicand
    // bit i survives only if its column i+j is at or above N-K.
    function automatic logic [AW-1:0] pp_f(
        input logic [N-1:0]    xv,
        input logic            yb,
        input logic            tm,
        input logic [CNTW-1:0] j
    );
        logic [N-1:0] xm;
        xm = '0;
        for (int i = 0; i < N; i++) begin
            if (!tm || ((i + int'(j)) >= (N - K))) begin
                xm[i] = xv[i];
            end else begin
                xm[i] = 1'b0;
            end
        end
        if (yb) begin
            pp_f = AW'(xm) << j;
        end else begin
            pp_f = '0;
        end
    endfunction

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign z         = z_r;
    assign sat       = sat_r;

    // Next-state logic for the IDLE -> BUSY -> FIN -> DONE sequence.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    accept_s = 1'b1;
                    state_s  = BUSY;
                end else begin
                    state_s  = IDLE;
                end
            end
            BUSY: begin
                if (count_r == LAST_CNT) begin
                    state_s = FIN;
                end else begin
                    state_s = BUSY;
                end
            end
            FIN: begin
                state_s = DONE;
            end
            DONE: begin
                if (out_valid_r && out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath combinational logic: the current partial product, plus the
    // final correction and saturation applied in FIN.
    always_comb begin
        pp_s      = pp_f(x_r, y_r[count_r], trunc_r, count_r);
        fin_sum_s = '0;
        hi_s      = '0;
        z_s       = '0;
        sat_s     = 1'b0;
        if (trunc_r) begin
            fin_sum_s = acc_r + CORR_EXT;
        end else begin
            fin_sum_s = acc_r;
        end
        hi_s = HW'(fin_sum_s >> N);
        // Exact mode cannot exceed 2^(2N)-1, so only truncated mode saturates.
        if (trunc_r && (hi_s[HW-1:N] != '0)) begin
            z_s   = '1;
            sat_s = 1'b1;
        end else begin
            z_s   = hi_s[N-1:0];
            sat_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latches, accumulator and bit counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_r     <= '0;
            y_r     <= '0;
            trunc_r <= 1'b0;
            acc_r   <= '0;
            count_r <= '0;
        end else if (accept_s) begin
            x_r     <= x;
            y_r     <= y;
            trunc_r <= trunc;
            acc_r   <= '0;
            count_r <= '0;
        end else if (state_r == BUSY) begin
            acc_r <= acc_r + pp_s;
            if (count_r == LAST_CNT) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + CNTW'(1);
            end
        end else begin
            acc_r   <= acc_r;
            count_r <= count_r;
        end
    end

    // Registered handshake flags and result. The result is captured in FIN
    // and held through DONE until the consumer takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            z_r         <= '0;
            sat_r       <= 1'b0;
        end else begin
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            if (state_r == FIN) begin
                z_r   <= z_s;
                sat_r <= sat_s;
            end else begin
                z_r   <= z_r;
                sat_r <= sat_r;
            end
        end
    end

endmodule

// File: tb/tb_trunc_mult_seq.sv
// Self-checking bench for trunc_mult_seq. Two N=4 instances (CORR=1 and
// CORR=31) share one stimulus for directed cases. An N=8 instance runs a
// randomized back-to-back stream that is checked against a bit-pair reference
// model through an in-order scoreboard.

module tb_trunc_mult_seq;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;

    logic       iv4 = 1'b0, ordy4 = 1'b0, t4 = 1'b0;
    logic [3:0] x4 = 4'd0, y4 = 4'd0;
    logic       ira, ova, sata, irb, ovb, satb;
    logic [3:0] za, zb;

    logic       iv8 = 1'b0, ordy8 = 1'b0, t8 = 1'b0;
    logic [7:0] x8 = 8'd0, y8 = 8'd0;
    logic       ir8, ov8, sat8;
    logic [7:0] z8;

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;

    trunc_mult_seq #(.N(4), .K(1), .CW(5), .CORR(1)) u_a (
        .clk(clk), .reset_n(reset_n), .in_valid(iv4), .in_ready(ira),
        .x(x4), .y(y4), .trunc(t4), .out_valid(ova), .out_ready(ordy4),
        .z(za), .sat(sata));

    trunc_mult_seq #(.N(4), .K(1), .CW(5), .CORR(31)) u_b (
        .clk(clk), .reset_n(reset_n), .in_valid(iv4), .in_ready(irb),
        .x(x4), .y(y4), .trunc(t4), .out_valid(ovb), .out_ready(ordy4),
        .z(zb), .sat(satb));

    trunc_mult_seq #(.N(8), .K(2), .CW(5), .CORR(3)) u_c (
        .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8),
        .x(x8), .y(y8), .trunc(t8), .out_valid(ov8), .out_ready(ordy8),
        .z(z8), .sat(sat8));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: returns (sat << 16) | z, computed from the arithmetic
    // definition by summing the kept bit pairs directly.
    function automatic int model(input int n, input int k, input int corr,
                                 input int xv, input int yv, input bit t);
        longint s;
        longint q;
        s = 0;
        if (!t) begin
            return int'((longint'(xv) * longint'(yv)) >> n);
        end
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                if ((((xv >> i) & 1) == 1) && (((yv >> j) & 1) == 1) && (i + j >= n - k)) begin
                    s += longint'(1) << (i + j);
                end
            end
        end
        s += longint'(corr) << (n - k);
        q = s >> n;
        if (q > ((longint'(1) << n) - 1)) begin
            return (1 << 16) | ((1 << n) - 1);
        end
        return int'(q);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One operation on the N=4 pair, with literal expectations for both
    // instances, followed by `hold` cycles of backpressure in DONE.
    task automatic op4(input int xv, input int yv, input bit t,
                       input int ea, input int esa, input int eb, input int esb,
                       input int hold);
        int c0;
        @(negedge clk);
        iv4 = 1'b1; x4 = 4'(xv); y4 = 4'(yv); t4 = t; ordy4 = 1'b0;
        chk("accept_ready", ira, 1);
        c0 = cyc;
        @(negedge clk);
        iv4 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ova) break;
            x4 = 4'($urandom); y4 = 4'($urandom); t4 = 1'($urandom_range(0, 1));
            iv4 = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        iv4 = 1'b0;
        chk("latency", cyc - c0, 6);
        chk("z_a", za, ea);
        chk("sat_a", sata, esa);
        chk("z_b", zb, eb);
        chk("sat_b", satb, esb);
        chk("valid_b", ovb, 1);
        chk("model_a", model(4, 1, 1, xv, yv, t), (esa << 16) | ea);
        for (int i = 0; i < hold; i++) begin
            iv4 = 1'($urandom_range(0, 1));
            x4 = 4'($urandom); y4 = 4'($urandom); t4 = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("bp_valid", ova, 1);
            chk("bp_z", za, ea);
            chk("bp_sat", sata, esa);
            chk("bp_ready", ira, 0);
        end
        iv4 = 1'b0;
        ordy4 = 1'b1;
        @(negedge clk);
        ordy4 = 1'b0;
        chk("post_valid", ova, 0);
        chk("post_ready", ira, 1);
    endtask

    initial begin
        int q[$];
        int accepted;
        int done;
        int guard;
        int seen;

        // Reset values.
        #2 reset_n = 1'b0;
        #2;
        chk("rst_ready", ira, 1);
        chk("rst_valid", ova, 0);
        chk("rst_z", za, 0);
        chk("rst_sat", sata, 0);
        chk("rst_ready8", ir8, 1);
        chk("rst_valid8", ov8, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Directed cases, all hand-computed.
        op4(15, 15, 1'b0, 14, 0, 14, 0, 0);
        op4(15, 15, 1'b1, 13, 0, 15, 1, 0);
        op4(11, 6, 1'b1, 4, 0, 15, 1, 0);
        op4(11, 6, 1'b0, 4, 0, 4, 0, 10);
        op4(0, 9, 1'b1, 0, 0, 15, 0, 0);

        // Asynchronous reset in BUSY at count=2 discards the operation.
        @(negedge clk);
        iv4 = 1'b1; x4 = 4'd9; y4 = 4'd9; t4 = 1'b0;
        @(negedge clk);
        iv4 = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", ira, 1);
        chk("mid_rst_valid", ova, 0);
        chk("mid_rst_z", za, 0);
        chk("mid_rst_sat", sata, 0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ova) seen++;
        end
        chk("no_result_after_rst", seen, 0);
        op4(3, 5, 1'b0, 0, 0, 0, 0, 0);

        // Randomized stream on the N=8 instance.
        accepted = 0;
        done = 0;
        guard = 0;
        while (done < 1000 && guard < 60000) begin
            @(negedge clk);
            guard++;
            iv8   = (accepted < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            x8    = 8'($urandom);
            y8    = 8'($urandom);
            t8    = 1'($urandom_range(0, 1));
            ordy8 = ($urandom_range(0, 3) != 0);
            #1;
            if (ov8) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("z8", z8, q[0] & 255);
                    chk("sat8", sat8, q[0] >> 16);
                    if (ordy8) begin
                        void'(q.pop_front());
                        done++;
                    end
                end
            end
            if (iv8 && ir8) begin
                q.push_back(model(8, 2, 3, int'(x8), int'(y8), t8));
                accepted++;
            end
        end
        chk("ops_done", done, 1000);
        chk("ops_accepted", accepted, 1000);
        chk("queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
